// File: rtl/bmc_stream_decoder.sv
// ---------------------------------------------------------------------------
// bmc_stream_decoder
//
// Biphase-mark (BMC) line decoder. The raw line is oversampled with clk,
// edge-to-edge intervals are measured and classified as glitch / short
// (half bit) / long (full bit) / over, and the resulting bits are assembled
// LSB first into WORD_W-bit words. Finished words go through a small FIFO
// and are offered on a valid/ready stream.
//
// Ports:
//   clk       - system clock
//   rst       - asynchronous, active-high reset
//   din       - raw BMC line, asynchronous to clk
//   m_valid   - FIFO head holds a word
//   m_ready   - consumer accepts the head word
//   m_data    - head word (WORD_W bits)
//   err_valid - one-cycle error pulse
//   err_code  - error cause, qualified by err_valid
//                 0 = truncated word at timeout, 1 = glitch,
//                 2 = bad short/long sequence,   3 = parity mismatch
//   overflow  - sticky, a finished word was dropped because the FIFO was full
//   busy      - FSM is inside a frame (RUN or HALF)
//
// Optional feature macro: BMC_PARITY_CHECK_EN
//   When defined, every word is followed by an even-parity bit. A parity
//   mismatch drops the word and raises error code 3.
// ---------------------------------------------------------------------------
module bmc_stream_decoder #(
  parameter int WORD_W     = 8,
  parameter int CNT_W      = 8,
  parameter int SHORT_MIN  = 2,
  parameter int SHORT_MAX  = 6,
  parameter int LONG_MAX   = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic              overflow,
  output logic              busy
);

`ifdef BMC_PARITY_CHECK_EN
  localparam int TOTAL_BITS = WORD_W + 1;
`else
  localparam int TOTAL_BITS = WORD_W;
`endif
  localparam int BCNT_W = $clog2(TOTAL_BITS + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALF
  } state_t;

  // Input synchroniser and edge history
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic sync3_q, sync3_d;
  logic edge_det;

  // Interval counter and classification
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic is_glitch, is_short, is_long, is_timeout;

  // Decoder FSM and word assembly
  state_t             state_q, state_d;
  logic [TOTAL_BITS-1:0] sr_q, sr_d;
  logic [TOTAL_BITS-1:0] word_next;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic               push_q, push_d;
  logic [WORD_W-1:0]  push_data_q, push_data_d;
  logic               err_valid_q, err_valid_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               take_bit, bit_val;
  logic               raise_err;
  logic [1:0]         err_cause;

  // Output FIFO
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [WORD_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              fifo_full, do_pop, do_write;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
  end

  assign edge_det = sync2_q ^ sync3_q;

  // The counter holds the length of the interval in progress; an edge
  // restarts it at 1 so that its value at the next edge equals the spacing.
  always_comb begin
    if (edge_det) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Classification uses the counter value before the edge reloads it.
  assign is_glitch  = cnt_q < CNT_W'(SHORT_MIN);
  assign is_short   = !is_glitch && (cnt_q <= CNT_W'(SHORT_MAX));
  assign is_long    = (cnt_q > CNT_W'(SHORT_MAX)) && (cnt_q <= CNT_W'(LONG_MAX));
  assign is_timeout = !edge_det && (cnt_q > CNT_W'(LONG_MAX));

  // Decoder: a long interval is a 0, two shorts make a 1. Any error throws
  // away the partial word; a completed word is handed to the FIFO stage.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bcnt_d      = bcnt_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    take_bit    = 1'b0;
    bit_val     = 1'b0;
    raise_err   = 1'b0;
    err_cause   = 2'd0;
    word_next   = sr_q;

    case (state_q)
      S_IDLE: begin
        if (edge_det) begin
          state_d = S_RUN;
          bcnt_d  = '0;
          sr_d    = '0;
        end
      end
      S_RUN: begin
        if (edge_det) begin
          if (is_glitch) begin
            state_d   = S_IDLE;
            raise_err = 1'b1;
            err_cause = 2'd1;
          end else if (is_short) begin
            state_d = S_HALF;
          end else if (is_long) begin
            take_bit = 1'b1;
            bit_val  = 1'b0;
          end else begin
            // Edge after an over-long gap starts a new frame in place.
            bcnt_d = '0;
            sr_d   = '0;
          end
        end else if (is_timeout) begin
          state_d = S_IDLE;
          bcnt_d  = '0;
          sr_d    = '0;
          if (bcnt_q != '0) begin
            raise_err = 1'b1;
            err_cause = 2'd0;
          end
        end
      end
      S_HALF: begin
        if (edge_det) begin
          if (is_glitch) begin
            state_d   = S_IDLE;
            raise_err = 1'b1;
            err_cause = 2'd1;
          end else if (is_short) begin
            state_d  = S_RUN;
            take_bit = 1'b1;
            bit_val  = 1'b1;
          end else if (is_long) begin
            state_d   = S_IDLE;
            raise_err = 1'b1;
            err_cause = 2'd2;
          end else begin
            state_d = S_RUN;
            bcnt_d  = '0;
            sr_d    = '0;
          end
        end else if (is_timeout) begin
          state_d = S_IDLE;
          bcnt_d  = '0;
          sr_d    = '0;
          if (bcnt_q != '0) begin
            raise_err = 1'b1;
            err_cause = 2'd0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // LSB first: the n-th decoded bit lands at position n.
    for (int i = 0; i < TOTAL_BITS; i++) begin
      if (bcnt_q == BCNT_W'(i)) begin
        word_next[i] = bit_val;
      end
    end

    if (take_bit) begin
      if (bcnt_q == BCNT_W'(TOTAL_BITS - 1)) begin
        sr_d   = '0;
        bcnt_d = '0;
`ifdef BMC_PARITY_CHECK_EN
        if (^word_next) begin
          raise_err = 1'b1;
          err_cause = 2'd3;
        end else begin
          push_d      = 1'b1;
          push_data_d = word_next[WORD_W-1:0];
        end
`else
        push_d      = 1'b1;
        push_data_d = word_next[WORD_W-1:0];
`endif
      end else begin
        sr_d   = word_next;
        bcnt_d = bcnt_q + BCNT_W'(1);
      end
    end

    // An error always suppresses a word finishing in the same clock.
    if (raise_err) begin
      err_valid_d = 1'b1;
      err_code_d  = err_cause;
      push_d      = 1'b0;
      sr_d        = '0;
      bcnt_d      = '0;
    end
  end

  // FIFO: a pop frees the head slot in the same clock, so a push into a
  // full FIFO is accepted when the consumer pops at the same time.
  always_comb begin
    fifo_full  = (count_q == FCNT_W'(FIFO_DEPTH));
    do_pop     = (count_q != '0) && m_ready;
    do_write   = push_q && (!fifo_full || do_pop);
    mem_d      = mem_q;
    if (do_write) begin
      mem_d[wr_ptr_q] = push_data_q;
    end
    wr_ptr_d   = wr_ptr_q + PTR_W'(do_write);
    rd_ptr_d   = rd_ptr_q + PTR_W'(do_pop);
    count_d    = count_q + FCNT_W'(do_write) - FCNT_W'(do_pop);
    overflow_d = overflow_q || (push_q && fifo_full && !do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      cnt_q       <= '0;
      state_q     <= S_IDLE;
      sr_q        <= '0;
      bcnt_q      <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      sr_q        <= sr_d;
      bcnt_q      <= bcnt_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      mem_q       <= mem_d;
    end
  end

  assign m_valid   = (count_q != '0);
  assign m_data    = mem_q[rd_ptr_q];
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_bmc_stream_decoder.sv
// ---------------------------------------------------------------------------
// tb_bmc_stream_decoder
//
// Drives BMC-encoded words into bmc_stream_decoder and checks the decoded
// stream, error pulses, overflow and busy against expectations derived from
// what was sent: every cleanly sent word is expected on the stream in order
// unless the model FIFO is already full, and each injected line fault has a
// known error code.
// ---------------------------------------------------------------------------
module tb_bmc_stream_decoder;

  localparam int WORD_W     = 8;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              din;
  logic              m_valid;
  logic              m_ready;
  logic [WORD_W-1:0] m_data;
  logic              err_valid;
  logic [1:0]        err_code;
  logic              overflow;
  logic              busy;

  int errors = 0;
  int checks = 0;

  logic [WORD_W-1:0] exp_q[$];
  logic [1:0]        err_seen[$];
  logic              exp_overflow;
  logic              rand_ready;
  logic [WORD_W-1:0] exp_word;

  bmc_stream_decoder #(
    .WORD_W(WORD_W),
    .CNT_W(8),
    .SHORT_MIN(2),
    .SHORT_MAX(6),
    .LONG_MAX(12),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .err_valid(err_valid),
    .err_code(err_code),
    .overflow(overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic waitClk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic doReset();
    rst        = 1'b1;
    din        = 1'b0;
    m_ready    = 1'b0;
    rand_ready = 1'b0;
    waitClk(3);
    rst = 1'b0;
    exp_q.delete();
    err_seen.delete();
    exp_overflow = 1'b0;
    waitClk(2);
  endtask

  task automatic toggleLine();
    din = ~din;
  endtask

  // One BMC cell: transition at the end of the cell, plus one mid-cell for a 1.
  task automatic sendBit(input logic b, input int half);
    if (b) begin
      waitClk(half);
      toggleLine();
      waitClk(half);
      toggleLine();
    end else begin
      waitClk(2 * half);
      toggleLine();
    end
  endtask

  // Sends one word (plus parity when enabled); a clean word is expected on
  // the stream unless the model FIFO is full, in which case overflow is due.
  task automatic applyStimulus(input logic [WORD_W-1:0] w, input int half, input logic bad_parity);
    for (int i = 0; i < WORD_W; i++) sendBit(w[i], half);
`ifdef BMC_PARITY_CHECK_EN
    sendBit((^w) ^ bad_parity, half);
`endif
    if (!bad_parity) begin
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(w);
      else exp_overflow = 1'b1;
    end
  endtask

  // Stream and error monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (err_valid) err_seen.push_back(err_code);
      if (m_valid && m_ready) begin
        if (exp_q.size() != 0) begin
          exp_word = exp_q.pop_front();
          checkOutput("pop_data", 32'(m_data), 32'(exp_word));
        end else begin
          checkOutput("pop_unexpected", 32'(m_valid), 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int half;
    int nwords;
    logic [WORD_W-1:0] w;

    rst        = 1'b1;
    din        = 1'b0;
    m_ready    = 1'b0;
    rand_ready = 1'b0;
    doReset();

    // Reset state
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_err_valid", 32'(err_valid), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_m_data", 32'(m_data), 32'd0);

    // Single word 0xA5 with latency measurement
    m_ready = 1'b1;
    waitClk(20);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    toggleLine();
    applyStimulus(8'hA5, 4, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("lat_before_4", 32'(m_valid), 32'd0);
    @(negedge clk);
    checkOutput("lat_at_4", 32'(m_valid), 32'd1);
    checkOutput("lat_data", 32'(m_data), 32'hA5);
    @(negedge clk);
    checkOutput("valid_once", 32'(m_valid), 32'd0);
    waitClk(20);
    checkOutput("t1_no_err", err_seen.size(), 32'd0);
    checkOutput("t1_drained", exp_q.size(), 32'd0);

    // Three words back to back, held by m_ready=0
    m_ready = 1'b0;
    waitClk(2);
    toggleLine();
    applyStimulus(8'h00, 4, 1'b0);
    applyStimulus(8'hFF, 4, 1'b0);
    applyStimulus(8'h3C, 4, 1'b0);
    waitClk(20);
    checkOutput("t2_valid_held", 32'(m_valid), 32'd1);
    checkOutput("t2_head", 32'(m_data), 32'h00);
    m_ready = 1'b1;
    waitClk(6);
    checkOutput("t2_drained", exp_q.size(), 32'd0);
    checkOutput("t2_m_valid", 32'(m_valid), 32'd0);
    checkOutput("t2_overflow", 32'(overflow), 32'd0);
    checkOutput("t2_no_err", err_seen.size(), 32'd0);

    // Five words into a four-entry FIFO
    doReset();
    toggleLine();
    for (int i = 0; i < 5; i++) applyStimulus(WORD_W'($urandom), 5, 1'b0);
    waitClk(20);
    checkOutput("t3_overflow_set", 32'(overflow), 32'(exp_overflow));
    m_ready = 1'b1;
    waitClk(8);
    checkOutput("t3_drained", exp_q.size(), 32'd0);
    checkOutput("t3_m_valid", 32'(m_valid), 32'd0);
    checkOutput("t3_overflow_sticky", 32'(overflow), 32'd1);
    doReset();
    checkOutput("t3_overflow_cleared", 32'(overflow), 32'd0);

    // Glitch mid-word, then a clean 0x5A
    m_ready = 1'b1;
    waitClk(5);
    toggleLine();
    sendBit(1'b1, 4);
    sendBit(1'b0, 4);
    sendBit(1'b1, 4);
    checkOutput("t4_busy_mid", 32'(busy), 32'd1);
    waitClk(2);
    toggleLine();
    waitClk(1);
    toggleLine();
    waitClk(20);
    checkOutput("t4_err_count", err_seen.size(), 32'd1);
    checkOutput("t4_err_code", 32'(err_seen[0]), 32'd1);
    checkOutput("t4_busy_after", 32'(busy), 32'd0);
    checkOutput("t4_no_word", 32'(m_valid), 32'd0);
    err_seen.delete();
    toggleLine();
    applyStimulus(8'h5A, 4, 1'b0);
    waitClk(20);
    checkOutput("t4_clean_drained", exp_q.size(), 32'd0);
    checkOutput("t4_clean_no_err", err_seen.size(), 32'd0);

    // Short followed by long
    toggleLine();
    sendBit(1'b0, 4);
    waitClk(4);
    toggleLine();
    waitClk(8);
    toggleLine();
    waitClk(20);
    checkOutput("t5_seq_count", err_seen.size(), 32'd1);
    checkOutput("t5_seq_code", 32'(err_seen[0]), 32'd2);
    checkOutput("t5_seq_busy", 32'(busy), 32'd0);
    err_seen.delete();

    // Truncated word: three bits then silence; the error pulse is due
    // 16 clocks after the final transition
    toggleLine();
    sendBit(1'b1, 4);
    sendBit(1'b1, 4);
    sendBit(1'b0, 4);
    repeat (16) @(negedge clk);
    checkOutput("t5_trunc_early", 32'(err_valid), 32'd0);
    @(negedge clk);
    checkOutput("t5_trunc_pulse", 32'(err_valid), 32'd1);
    checkOutput("t5_trunc_code", 32'(err_code), 32'd0);
    waitClk(5);
    checkOutput("t5_trunc_count", err_seen.size(), 32'd1);
    checkOutput("t5_trunc_busy", 32'(busy), 32'd0);
    checkOutput("t5_trunc_no_word", 32'(m_valid), 32'd0);
    err_seen.delete();

    // Random bursts with random half-bit period and random m_ready
    rand_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      half   = $urandom_range(4, 6);
      nwords = $urandom_range(1, 3);
      toggleLine();
      for (int k = 0; k < nwords; k++) begin
        w = WORD_W'($urandom);
        applyStimulus(w, half, 1'b0);
      end
      waitClk(20);
    end
    rand_ready = 1'b0;
    m_ready    = 1'b1;
    waitClk(10);
    checkOutput("rand_drained", exp_q.size(), 32'd0);
    checkOutput("rand_no_err", err_seen.size(), 32'd0);
    checkOutput("rand_overflow", 32'(overflow), 32'd0);

`ifdef BMC_PARITY_CHECK_EN
    // Parity: good parity accepted, bad parity rejected with code 3
    toggleLine();
    applyStimulus(8'h81, 4, 1'b0);
    waitClk(20);
    checkOutput("par_good_drained", exp_q.size(), 32'd0);
    checkOutput("par_good_no_err", err_seen.size(), 32'd0);
    toggleLine();
    applyStimulus(8'h81, 4, 1'b1);
    waitClk(20);
    checkOutput("par_bad_count", err_seen.size(), 32'd1);
    checkOutput("par_bad_code", 32'(err_seen[0]), 32'd3);
    checkOutput("par_bad_no_word", 32'(m_valid), 32'd0);
    err_seen.delete();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
